// File: rtl/word_read_temp_latch.sv
// word_read_temp_latch
//   Atomic 16-bit reads over an 8-bit bus using one shared TEMP byte.
//   A low-byte read returns the low byte and snapshots the high byte into TEMP.
//   A later high-byte read returns TEMP, so the CPU sees a coherent word even
//   if the live register changed in between.
//
//   Optional build macro: WORD_READ_ERR_EN
//     When defined, rd_err pulses alongside dout_valid for two cases:
//     a high-byte read with no pending snapshot, or both strobes in the same cycle.
//     When undefined, rd_err is tied low and no error logic is built.
//
// Ports
//   clk         system clock, rising edge
//   clr         asynchronous active-high reset
//   src_bus     live register values, reg i = src_bus[i*2*BYTE_W +: 2*BYTE_W]
//   rd_addr     register select, sampled with rd_lo (ignored on rd_hi)
//   rd_lo       low-byte read strobe
//   rd_hi       high-byte read strobe
//   dout        registered read data, holds between reads
//   dout_valid  one-cycle pulse, dout valid
//   temp_full   TEMP holds an unconsumed snapshot
//   rd_err      protocol error pulse (WORD_READ_ERR_EN builds only)
module word_read_temp_latch #(
  parameter int                BYTE_W   = 8,
  parameter int                NUM_REGS = 4,
  parameter int                ADDR_W   = 2,
  parameter logic [BYTE_W-1:0] RESETVAL = '0
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [NUM_REGS*2*BYTE_W-1:0] src_bus,
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic                         rd_lo,
  input  logic                         rd_hi,
  output logic [BYTE_W-1:0]            dout,
  output logic                         dout_valid,
  output logic                         temp_full,
  output logic                         rd_err
);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] temp_q, temp_d;
  logic [BYTE_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic [2*BYTE_W-1:0] sel_word;

  // Source select; an address with no matching register yields zero.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) sel_word = src_bus[i*2*BYTE_W +: 2*BYTE_W];
    end
  end

  // rd_lo has priority; a coincident rd_hi is dropped.
  always_comb begin
    state_d      = state_q;
    temp_d       = temp_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (rd_lo) begin
      dout_d       = sel_word[BYTE_W-1:0];
      temp_d       = sel_word[2*BYTE_W-1:BYTE_W];
      dout_valid_d = 1'b1;
      state_d      = HELD;
    end else if (rd_hi) begin
      // TEMP is kept after consumption so a stray rd_hi returns the last snapshot.
      dout_d       = temp_q;
      dout_valid_d = 1'b1;
      state_d      = IDLE;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      temp_q       <= RESETVAL;
      dout_q       <= RESETVAL;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      temp_q       <= temp_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign temp_full  = (state_q == HELD);

`ifdef WORD_READ_ERR_EN
  logic rd_err_q, rd_err_d;

  // rd_hi with nothing pending, or rd_hi colliding with rd_lo.
  always_comb begin
    rd_err_d = rd_hi && (rd_lo || (state_q == IDLE));
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) rd_err_q <= 1'b0;
    else     rd_err_q <= rd_err_d;
  end

  assign rd_err = rd_err_q;
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_word_read_temp_latch.sv
// Directed bench for word_read_temp_latch (NUM_REGS=3 so address 3 is out of range).
// A word-level reference model runs on every edge; a compare process checks it
// each negedge, and the stimulus sequence pins hand-computed literal values.
module tb_word_read_temp_latch;
  localparam int        BYTE_W = 8;
  localparam int        NREG   = 3;
  localparam int        AW     = 2;
  localparam logic [7:0] RV    = 8'h3C;
`ifdef WORD_READ_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic [15:0]       src_w [NREG];
  logic [NREG*16-1:0] src_bus;
  logic [AW-1:0]     rd_addr = '0;
  logic              rd_lo = 1'b0, rd_hi = 1'b0;
  logic [7:0]        dout;
  logic              dout_valid, temp_full, rd_err;

  int n_chk = 0, n_fail = 0;
  bit started = 1'b0;

  assign src_bus = {src_w[2], src_w[1], src_w[0]};

  always #5 clk = ~clk;

  word_read_temp_latch #(.BYTE_W(BYTE_W), .NUM_REGS(NREG), .ADDR_W(AW), .RESETVAL(RV)) dut (
    .clk(clk), .clr(clr), .src_bus(src_bus), .rd_addr(rd_addr), .rd_lo(rd_lo),
    .rd_hi(rd_hi), .dout(dout), .dout_valid(dout_valid), .temp_full(temp_full), .rd_err(rd_err)
  );

  // Reference model: a snapshot word plus a pending flag.
  logic [7:0] m_dout = RV, m_temp = RV;
  logic       m_vld = 1'b0, m_held = 1'b0, m_err = 1'b0;

  always @(posedge clk or posedge clr) begin
    logic [15:0] w;
    if (clr) begin
      m_dout = RV; m_temp = RV; m_vld = 1'b0; m_held = 1'b0; m_err = 1'b0;
    end else begin
      m_vld = rd_lo | rd_hi;
      m_err = ERR_ON && rd_hi && (rd_lo || !m_held);
      if (rd_lo) begin
        w = (int'(rd_addr) < NREG) ? src_w[rd_addr] : 16'h0000;
        m_dout = w[7:0];
        m_temp = w[15:8];
        m_held = 1'b1;
      end else if (rd_hi) begin
        m_dout = m_temp;
        m_held = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started && !clr) begin
      chk("model_dout", 16'(dout), 16'(m_dout));
      chk("model_valid", 16'(dout_valid), 16'(m_vld));
      chk("model_full", 16'(temp_full), 16'(m_held));
      chk("model_err", 16'(rd_err), 16'(m_err));
    end
  end

  // Called at #1 after a posedge; returns #1 after the edge that registers the result.
  task automatic pulse(input logic lo, input logic hi, input logic [AW-1:0] a);
    rd_lo = lo; rd_hi = hi; rd_addr = a;
    @(posedge clk); #1;
    rd_lo = 1'b0; rd_hi = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse();
    clr = 1'b1; #2; clr = 1'b0;
    idle();
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) src_w[i] = 16'h0000;
    #1 clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    started = 1'b1;
    chk("reset_dout", 16'(dout), 16'(RV));
    chk("reset_valid", 16'(dout_valid), 16'h0);
    chk("reset_full", 16'(temp_full), 16'h0);
    chk("reset_err", 16'(rd_err), 16'h0);

    // 1: coherent read despite live change
    src_w[0] = 16'hA55A;
    pulse(1, 0, 0);
    chk("t1_lo_dout", 16'(dout), 16'h005A);
    chk("t1_lo_valid", 16'(dout_valid), 16'h1);
    chk("t1_lo_full", 16'(temp_full), 16'h1);
    src_w[0] = 16'h1234;
    idle();
    chk("t1_gap_valid", 16'(dout_valid), 16'h0);
    chk("t1_gap_hold", 16'(dout), 16'h005A);
    pulse(0, 1, 0);
    chk("t1_hi_dout", 16'(dout), 16'h00A5);
    chk("t1_hi_full", 16'(temp_full), 16'h0);

    // 2: TEMP shared across registers, rd_addr ignored on rd_hi
    src_w[1] = 16'hBEEF; src_w[2] = 16'h0000;
    pulse(1, 0, 1);
    chk("t2_lo_dout", 16'(dout), 16'h00EF);
    pulse(0, 1, 2);
    chk("t2_hi_dout", 16'(dout), 16'h00BE);
    // stale rd_hi in IDLE returns retained TEMP
    pulse(0, 1, 0);
    chk("t2_stale_dout", 16'(dout), 16'h00BE);
    chk("t2_stale_err", 16'(rd_err), 16'(ERR_ON));

    // 3: rd_hi right after reset
    reset_pulse();
    pulse(0, 1, 0);
    chk("t3_dout", 16'(dout), 16'(RV));
    chk("t3_valid", 16'(dout_valid), 16'h1);
    chk("t3_full", 16'(temp_full), 16'h0);
    chk("t3_err", 16'(rd_err), 16'(ERR_ON));

    // 4: both strobes together, rd_lo wins
    src_w[0] = 16'hC3D4;
    pulse(1, 1, 0);
    chk("t4_dout", 16'(dout), 16'h00D4);
    chk("t4_valid", 16'(dout_valid), 16'h1);
    chk("t4_full", 16'(temp_full), 16'h1);
    chk("t4_err", 16'(rd_err), 16'(ERR_ON));
    idle();
    chk("t4_single_pulse", 16'(dout_valid), 16'h0);
    pulse(0, 1, 0);
    chk("t4_hi_dout", 16'(dout), 16'h00C3);
    chk("t4_hi_err", 16'(rd_err), 16'h0);

    // 5: reset while HELD discards the snapshot
    src_w[2] = 16'h7788;
    pulse(1, 0, 2);
    chk("t5_lo_dout", 16'(dout), 16'h0088);
    reset_pulse();
    chk("t5_clr_full", 16'(temp_full), 16'h0);
    pulse(0, 1, 0);
    chk("t5_hi_dout", 16'(dout), 16'(RV));
    chk("t5_hi_full", 16'(temp_full), 16'h0);

    // 6: out-of-range address yields zero for both bytes
    src_w[0] = 16'h1111; src_w[1] = 16'h2222; src_w[2] = 16'h3333;
    pulse(1, 0, 3);
    chk("t6_lo_dout", 16'(dout), 16'h0000);
    chk("t6_lo_full", 16'(temp_full), 16'h1);
    pulse(0, 1, 1);
    chk("t6_hi_dout", 16'(dout), 16'h0000);

    // second rd_lo while HELD overwrites TEMP
    src_w[1] = 16'hBEEF;
    pulse(1, 0, 0);
    chk("ovr_lo1", 16'(dout), 16'h0011);
    pulse(1, 0, 1);
    chk("ovr_lo2", 16'(dout), 16'h00EF);
    pulse(0, 1, 0);
    chk("ovr_hi", 16'(dout), 16'h00BE);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
